// File: rtl/midi_out_arbiter.sv
// midi_out_arbiter
//   Shares one MIDI UART transmitter among N_IN deserialized MIDI input byte
//   streams. One input is locked for a whole MIDI message, so messages from
//   different inputs never interleave. Inputs are picked round-robin among
//   those whose route_mask bit is set.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   route_mask    per-input forwarding enable (sampled for arbitration in IDLE)
//   in_byte       input i byte at [8*i+7:8*i]
//   in_valid      input i byte present
//   in_ready      input i byte consumed this cycle (only the granted input)
//   tx_byte       registered byte to the UART TX
//   tx_valid      registered tx_byte valid, held until tx_ready
//   tx_ready      UART TX accepts tx_byte
//   grant_idx     currently / last granted input
//   busy          a message lock is active
//   timeout_err   one-cycle pulse when a lock is abandoned for inactivity
module midi_out_arbiter #(
    parameter int unsigned N_IN        = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   route_mask,
    input  logic [8*N_IN-1:0] in_byte,
    input  logic [N_IN-1:0]   in_valid,
    output logic [N_IN-1:0]   in_ready,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [2:0]        grant_idx,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_BODY,
        S_SYSEX
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_valid_q, tx_valid_d;
    logic             terr_q, terr_d;

    logic [7:0]       cur_byte;
    logic             cur_valid;
    logic             cur_mask;
    logic             slot_free;
    logic             is_rt;
    logic             acceptable;
    logic             consume;
    logic             forward;
    logic [N_IN-1:0]  req;
    logic             rr_found;
    logic [2:0]       rr_idx;

    // Mux out the granted input by comparison so no variable index is needed.
    always_comb begin
        cur_byte  = '0;
        cur_valid = 1'b0;
        cur_mask  = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (grant_q == 3'(i)) begin
                cur_byte  = in_byte[8*i +: 8];
                cur_valid = in_valid[i];
                cur_mask  = route_mask[i];
            end
        end
    end

    // Round-robin: the first requester at offsets 1..N_IN after the last grant.
    always_comb begin
        req      = in_valid & route_mask;
        rr_found = 1'b0;
        rr_idx   = grant_q;
        for (int unsigned off = 1; off <= N_IN; off++) begin
            for (int unsigned j = 0; j < N_IN; j++) begin
                if (!rr_found && req[j] && ((32'(grant_q) + off) % N_IN == j)) begin
                    rr_found = 1'b1;
                    rr_idx   = 3'(j);
                end
            end
        end
    end

    assign slot_free = !tx_valid_q || tx_ready;
    assign is_rt     = (cur_byte >= 8'hF8);

    // Which bytes the current state is willing to take; anything else is an
    // interrupting status byte that ends the message without being consumed.
    always_comb begin
        case (state_q)
            S_HEAD:  acceptable = 1'b1;
            S_BODY:  acceptable = !cur_byte[7] || is_rt;
            S_SYSEX: acceptable = !cur_byte[7] || is_rt || (cur_byte == 8'hF7);
            default: acceptable = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q & ~tx_ready;
        terr_d     = 1'b0;
        consume    = 1'b0;
        forward    = 1'b0;

        if (state_q == S_IDLE) begin
            if (rr_found) begin
                grant_d = rr_idx;
                state_d = S_HEAD;
                cnt_d   = '0;
            end
        end else if (!cur_mask) begin
            state_d = S_IDLE;
        end else if (cur_valid && acceptable && slot_free) begin
            consume = 1'b1;
            cnt_d   = '0;
            case (state_q)
                S_HEAD: begin
                    if (!cur_byte[7]) begin
                        // Orphan data byte: swallowed, never forwarded.
                        state_d = S_IDLE;
                    end else begin
                        forward = 1'b1;
                        case (cur_byte[7:4])
                            4'hC, 4'hD: begin
                                rem_d   = 2'd1;
                                state_d = S_BODY;
                            end
                            4'hF: begin
                                case (cur_byte[3:0])
                                    4'h0: begin
                                        rem_d   = 2'd0;
                                        state_d = S_SYSEX;
                                    end
                                    4'h1, 4'h3: begin
                                        rem_d   = 2'd1;
                                        state_d = S_BODY;
                                    end
                                    4'h2: begin
                                        rem_d   = 2'd2;
                                        state_d = S_BODY;
                                    end
                                    default: begin
                                        rem_d   = 2'd0;
                                        state_d = S_IDLE;
                                    end
                                endcase
                            end
                            default: begin
                                rem_d   = 2'd2;
                                state_d = S_BODY;
                            end
                        endcase
                    end
                end
                S_BODY: begin
                    forward = 1'b1;
                    // Realtime bytes pass through without counting.
                    if (!cur_byte[7]) begin
                        rem_d = rem_q - 2'd1;
                        if (rem_q == 2'd1) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_SYSEX: begin
                    forward = 1'b1;
                    if (cur_byte == 8'hF7) begin
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end else if (cur_valid && !acceptable) begin
            state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            // This idle cycle brings the count to TIMEOUT_CYC.
            state_d = S_IDLE;
            terr_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (consume && forward) begin
            tx_valid_d = 1'b1;
            tx_byte_d  = cur_byte;
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < N_IN; j++) begin
            in_ready[j] = consume && (grant_q == 3'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= 3'(N_IN - 1);
            rem_q      <= '0;
            cnt_q      <= '0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            terr_q     <= terr_d;
        end
    end

    assign tx_byte     = tx_byte_q;
    assign tx_valid    = tx_valid_q;
    assign grant_idx   = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_midi_out_arbiter.sv
// tb_midi_out_arbiter
//   Self-checking bench for midi_out_arbiter (N_IN=4, TIMEOUT_CYC=16).
module tb_midi_out_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   route_mask;
    logic [8*N-1:0] in_byte;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [7:0]     tx_byte;
    logic           tx_valid;
    logic           tx_ready;
    logic [2:0]     grant_idx;
    logic           busy;
    logic           timeout_err;

    always #5 clk = ~clk;

    midi_out_arbiter #(
        .N_IN        (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .route_mask  (route_mask),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] src_q [N][$];
    int         gap [N];
    logic [7:0] txlog [$];
    int         txmode;
    bit         rand_gaps;
    int         txr_zero_run;
    int         terr_seen;

    logic [N-1:0] s_in_ready;
    logic         s_tx_valid;
    logic [7:0]   s_tx_byte;
    logic         s_busy;
    logic         s_terr;
    logic [2:0]   s_grant;
    logic         p_valid, p_ready, p_rst;
    logic [7:0]   p_byte;

    // Reference model state for the randomized run.
    logic [7:0] ex_q [N][$];
    int         len_q [N][$];

    typedef struct {
        int          ia;
        logic [95:0] a;
        int          na;
        int          ib;
        logic [95:0] b;
        int          nb;
        logic [3:0]  mask;
        int          txm;
        logic [95:0] e;
        int          ne;
        int          left;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            in_valid[i]       = (src_q[i].size() > 0) && (gap[i] == 0);
            in_byte[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
    endtask

    // One clock: sample at negedge, then update stimulus 1 time unit after posedge.
    task automatic step();
        logic [N-1:0] cons;
        @(negedge clk);
        s_in_ready = in_ready;
        s_tx_valid = tx_valid;
        s_tx_byte  = tx_byte;
        s_busy     = busy;
        s_terr     = timeout_err;
        s_grant    = grant_idx;
        check("in_ready_legal", {31'd0, $onehot0(in_ready) && ((in_ready & ~in_valid) == '0)}, 32'd1);
        if (p_valid && !p_ready && !p_rst && !rst) begin
            check("tx_hold", {23'd0, tx_valid, tx_byte}, {23'd0, 1'b1, p_byte});
        end
        p_valid = tx_valid;
        p_ready = tx_ready;
        p_byte  = tx_byte;
        p_rst   = rst;
        cons = in_valid & in_ready;
        if (tx_valid && tx_ready) txlog.push_back(tx_byte);
        if (timeout_err) terr_seen++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (cons[i]) begin
                void'(src_q[i].pop_front());
                if (rand_gaps) gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end else if (gap[i] > 0) begin
                gap[i]--;
            end
        end
        case (txmode)
            1: tx_ready = ~tx_ready;
            2: begin
                if (txr_zero_run >= 3) tx_ready = 1'b1;
                else tx_ready = 1'($urandom_range(0, 1));
                txr_zero_run = tx_ready ? 0 : txr_zero_run + 1;
            end
            default: tx_ready = 1'b1;
        endcase
        drive_inputs();
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            gap[i] = 0;
        end
        txlog.delete();
        terr_seen = 0;
    endtask

    // Reset with every input offering a byte: nothing may be consumed.
    task automatic do_reset();
        rst        = 1'b1;
        route_mask = '1;
        txmode     = 0;
        tx_ready   = 1'b1;
        rand_gaps  = 1'b0;
        clear_all();
        for (int i = 0; i < N; i++) src_q[i].push_back(8'h90);
        drive_inputs();
        repeat (3) step();
        check("rst_in_ready", {28'd0, s_in_ready}, 32'd0);
        check("rst_tx_valid", {31'd0, s_tx_valid}, 32'd0);
        check("rst_tx_byte", {24'd0, s_tx_byte}, 32'd0);
        check("rst_grant", {29'd0, s_grant}, N - 1);
        check("rst_busy", {31'd0, s_busy}, 32'd0);
        check("rst_timeout", {31'd0, s_terr}, 32'd0);
        rst = 1'b0;
        clear_all();
        drive_inputs();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int left;
        do_reset();
        route_mask = v.mask;
        txmode     = v.txm;
        for (int k = 0; k < v.na; k++) src_q[v.ia].push_back(v.a[8*(v.na-1-k) +: 8]);
        if (v.ib >= 0) begin
            for (int k = 0; k < v.nb; k++) src_q[v.ib].push_back(v.b[8*(v.nb-1-k) +: 8]);
        end
        drive_inputs();
        repeat (60) step();
        check($sformatf("vec%0d_len", idx), txlog.size(), v.ne);
        for (int k = 0; k < v.ne; k++) begin
            if (k < txlog.size())
                check($sformatf("vec%0d_byte%0d", idx, k), {24'd0, txlog[k]}, {24'd0, v.e[8*(v.ne-1-k) +: 8]});
        end
        left = 0;
        for (int i = 0; i < N; i++) left += src_q[i].size();
        check($sformatf("vec%0d_left", idx), left, v.left);
        check($sformatf("vec%0d_timeout", idx), terr_seen, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int found;
        int owner;
        int rem;
        int left;
        int cyc;
        bit all_empty;
        logic [7:0] b;
        logic [7:0] e;
        logic [7:0] msg [$];

        p_valid = 1'b0; p_ready = 1'b0; p_rst = 1'b1; p_byte = '0;
        txr_zero_run = 0;
        in_valid = '0;
        in_byte  = '0;

        vecs[0] = '{ia:2, a:96'h903CF87F, na:4, ib:-1, b:96'h0, nb:0, mask:4'hF, txm:0,
                    e:96'h903CF87F, ne:4, left:0};
        vecs[1] = '{ia:1, a:96'hF07E01F7, na:4, ib:-1, b:96'h0, nb:0, mask:4'hF, txm:1,
                    e:96'hF07E01F7, ne:4, left:0};
        vecs[2] = '{ia:0, a:96'h901020901121, na:6, ib:1, b:96'h913041913141, nb:6, mask:4'hF, txm:0,
                    e:96'h901020913041901121913141, ne:12, left:0};
        vecs[3] = '{ia:0, a:96'hC005F6F4E00102, na:7, ib:-1, b:96'h0, nb:0, mask:4'hF, txm:0,
                    e:96'hC005F6F4E00102, ne:7, left:0};
        vecs[4] = '{ia:3, a:96'h903C803C00, na:5, ib:-1, b:96'h0, nb:0, mask:4'hF, txm:0,
                    e:96'h903C803C00, ne:5, left:0};
        vecs[5] = '{ia:1, a:96'hF001F802903C40, na:7, ib:-1, b:96'h0, nb:0, mask:4'hF, txm:1,
                    e:96'hF001F802903C40, ne:7, left:0};
        vecs[6] = '{ia:0, a:96'h3CF105F20102, na:6, ib:-1, b:96'h0, nb:0, mask:4'hF, txm:0,
                    e:96'hF105F20102, ne:5, left:0};
        vecs[7] = '{ia:2, a:96'hF8F37FFE, na:4, ib:-1, b:96'h0, nb:0, mask:4'hF, txm:0,
                    e:96'hF8F37FFE, ne:4, left:0};
        vecs[8] = '{ia:1, a:96'h904040, na:3, ib:3, b:96'h904040, nb:3, mask:4'h5, txm:0,
                    e:96'h0, ne:0, left:6};
        vecs[9] = '{ia:1, a:96'h40, na:1, ib:-1, b:96'h0, nb:0, mask:4'h2, txm:0,
                    e:96'h0, ne:0, left:0};

        // Cycle-exact single message: one-cycle consume-to-tx latency.
        do_reset();
        src_q[0].push_back(8'h90);
        src_q[0].push_back(8'h3C);
        src_q[0].push_back(8'h7F);
        drive_inputs();
        step();
        check("t1_idle_ready", {28'd0, s_in_ready}, 32'd0);
        check("t1_idle_busy", {31'd0, s_busy}, 32'd0);
        step();
        check("t1_head_ready", {28'd0, s_in_ready}, 32'h1);
        check("t1_head_grant", {29'd0, s_grant}, 32'd0);
        check("t1_head_txv", {31'd0, s_tx_valid}, 32'd0);
        step();
        check("t1_tx0", {23'd0, s_tx_valid, s_tx_byte}, {23'd0, 1'b1, 8'h90});
        step();
        check("t1_tx1", {23'd0, s_tx_valid, s_tx_byte}, {23'd0, 1'b1, 8'h3C});
        check("t1_busy_mid", {31'd0, s_busy}, 32'd1);
        step();
        check("t1_tx2", {23'd0, s_tx_valid, s_tx_byte}, {23'd0, 1'b1, 8'h7F});
        check("t1_busy_end", {31'd0, s_busy}, 32'd0);
        step();
        check("t1_tx_idle", {31'd0, s_tx_valid}, 32'd0);

        // Transaction-level table.
        for (int t = 0; t < 10; t++) run_vec(vecs[t], t);

        // Timeout: B0 then silence.
        do_reset();
        src_q[3].push_back(8'hB0);
        drive_inputs();
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            step();
            if (s_in_ready[3]) found = 1;
        end
        check("t5_consume", found, 1);
        n = 0;
        s_terr = 1'b0;
        while (n < 40 && !s_terr) begin
            step();
            n++;
        end
        // Pulse is registered on the 16th clock edge after the consume edge.
        check("t5_delay", n, 17);
        check("t5_busy", {31'd0, s_busy}, 32'd0);
        step();
        check("t5_pulse_width", {31'd0, s_terr}, 32'd0);
        src_q[1].push_back(8'hC1);
        src_q[1].push_back(8'h05);
        drive_inputs();
        repeat (8) step();
        check("t5_txlen", txlog.size(), 3);
        if (txlog.size() == 3) begin
            check("t5_tx0", {24'd0, txlog[0]}, 32'hB0);
            check("t5_tx1", {24'd0, txlog[1]}, 32'hC1);
            check("t5_tx2", {24'd0, txlog[2]}, 32'h05);
        end
        check("t5_pulses", terr_seen, 1);

        // route_mask cleared mid-message.
        do_reset();
        src_q[0].push_back(8'h90);
        src_q[0].push_back(8'h3C);
        drive_inputs();
        for (int k = 0; k < 10 && src_q[0].size() > 0; k++) step();
        check("mk_loaded", src_q[0].size(), 0);
        route_mask = 4'b1110;
        src_q[0].push_back(8'h7F);
        drive_inputs();
        step();
        check("mk_abort_ready", {28'd0, s_in_ready}, 32'd0);
        check("mk_abort_busy0", {31'd0, s_busy}, 32'd1);
        step();
        check("mk_abort_busy1", {31'd0, s_busy}, 32'd0);
        repeat (3) step();
        check("mk_left", src_q[0].size(), 1);
        check("mk_txlen", txlog.size(), 2);
        check("mk_timeout", terr_seen, 0);

        // Randomized traffic from all inputs against a message-level model.
        do_reset();
        txmode    = 2;
        rand_gaps = 1'b1;
        for (int i = 0; i < N; i++) begin
            ex_q[i].delete();
            len_q[i].delete();
            for (int m = 0; m < 25; m++) begin
                msg.delete();
                case ($urandom_range(0, 2))
                    0: begin
                        msg.push_back(8'h90 | 8'(i));
                        msg.push_back(8'($urandom_range(0, 127)));
                        msg.push_back(8'($urandom_range(0, 127)));
                    end
                    1: begin
                        msg.push_back(8'hC0 | 8'(i));
                        msg.push_back(8'($urandom_range(0, 127)));
                    end
                    default: begin
                        msg.push_back(8'hB0 | 8'(i));
                        msg.push_back(8'($urandom_range(0, 127)));
                        msg.push_back(8'($urandom_range(0, 127)));
                    end
                endcase
                if ($urandom_range(0, 3) == 0) msg.insert($urandom_range(1, msg.size() - 1), 8'hF8);
                len_q[i].push_back(msg.size());
                foreach (msg[k]) begin
                    src_q[i].push_back(msg[k]);
                    ex_q[i].push_back(msg[k]);
                end
            end
        end
        drive_inputs();
        cyc = 0;
        all_empty = 1'b0;
        while (!all_empty && cyc < 5000) begin
            step();
            cyc++;
            all_empty = 1'b1;
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) all_empty = 1'b0;
        end
        check("rand_drain", {31'd0, all_empty}, 32'd1);
        txmode = 0;
        repeat (6) step();
        rand_gaps = 1'b0;
        check("rand_timeout", terr_seen, 0);

        owner = 0;
        rem   = 0;
        foreach (txlog[k]) begin
            b = txlog[k];
            if (rem == 0) begin
                found = (b[7] && (b[7:4] != 4'hF) && (int'(b[3:0]) < N)) ? 1 : 0;
                if (found == 1 && len_q[int'(b[3:0])].size() == 0) found = 0;
                check($sformatf("rand_msgstart%0d", k), found, 1);
                if (found == 0) break;
                owner = int'(b[3:0]);
                rem   = len_q[owner].pop_front();
            end
            e = (ex_q[owner].size() > 0) ? ex_q[owner].pop_front() : 8'hXX;
            check($sformatf("rand_byte%0d", k), {24'd0, b}, {24'd0, e});
            rem--;
        end
        left = rem;
        for (int i = 0; i < N; i++) left += ex_q[i].size();
        check("rand_leftover", left, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
